// File: rtl/coeff_bus_initiator.sv
// coeff_bus_initiator: streams N coefficients into the FIR controller via arm/setup/write/readback/close bus sequence
module coeff_bus_initiator #(
   parameter int P_TAP_MAX = 64,
   parameter int P_DW = 16
) (
   input  logic                         iClk_12M,
   input  logic                         iRsn,
   input  logic                         iStart,
   input  logic [$clog2(P_TAP_MAX):0]   iNumTap,
   input  logic                         iCoeffValid,
   input  logic [P_DW-1:0]              iCoeff,
   output logic                         oCoeffReady,
   output logic                         oCoeffiUpdateFlag,
   output logic                         oCsnRam,
   output logic                         oWrnRam,
   output logic [$clog2(P_TAP_MAX)-1:0] oAddrRam,
   output logic [P_DW-1:0]              oWrDtRam,
   output logic                         oBusy,
   output logic                         oDone,
   output logic                         oErr
);
   localparam int AW = $clog2(P_TAP_MAX);
   localparam logic [AW:0] TapMax = P_TAP_MAX[AW:0];
   typedef enum logic [2:0] {sIdle, sArm, sSetup, sWrite, sRead, sClose} tState;
   tState state, nextState;
   logic [AW:0] numTap, cnt, nCnt, cntInc;
   logic [AW-1:0] nAddr;
   logic [P_DW-1:0] nData;
   logic nFlag, nCsn, accept, legal;
   assign oCoeffReady = (state == sSetup || state == sWrite) && cnt < numTap;
   assign accept = iCoeffValid & oCoeffReady;
   assign legal = iNumTap != '0 && iNumTap <= TapMax;
   assign cntInc = cnt + 1'b1;
   always_comb begin
      nextState = state;
      nCnt = cnt;
      unique case (state)
         sIdle: begin
            nCnt = '0;
            if (iStart && legal) nextState = sArm;
         end
         sArm: nextState = sSetup;
         sSetup: begin
            nextState = sWrite;
            if (accept) nCnt = cntInc;
         end
         sWrite:
            if (cnt == numTap) begin
               nextState = sRead;
               nCnt = '0;
            end else if (accept) nCnt = cntInc;
         sRead: begin
            nCnt = cntInc;
            if (cntInc == numTap) nextState = sClose;
         end
         sClose: begin
            nextState = sIdle;
            nCnt = '0;
         end
         default: nextState = sIdle;
      endcase
      // a stalled write cycle deselects the RAM but keeps the last address/data on the bus
      nAddr = nextState == sWrite ? (accept ? cnt[AW-1:0] : oAddrRam) :
              (nextState == sRead && state == sRead) ? cntInc[AW-1:0] : '0;
      nData = nextState == sWrite ? (accept ? iCoeff : oWrDtRam) : '0;
      nCsn = !(nextState == sSetup || nextState == sRead || (nextState == sWrite && accept));
      nFlag = nextState == sArm || nextState == sSetup || nextState == sWrite;
   end
   always_ff @(posedge iClk_12M or negedge iRsn)
      if (!iRsn) begin
         state <= sIdle;
         numTap <= '0;
         cnt <= '0;
         oCoeffiUpdateFlag <= 1'b0;
         oCsnRam <= 1'b1;
         oWrnRam <= 1'b1;
         oAddrRam <= '0;
         oWrDtRam <= '0;
         oBusy <= 1'b0;
         oDone <= 1'b0;
         oErr <= 1'b0;
      end else begin
         state <= nextState;
         cnt <= nCnt;
         if (state == sIdle && iStart && legal) numTap <= iNumTap;
         oCoeffiUpdateFlag <= nFlag;
         oCsnRam <= nCsn;
         oWrnRam <= !nFlag;
         oAddrRam <= nAddr;
         oWrDtRam <= nData;
         oBusy <= nextState != sIdle;
         oDone <= nextState == sClose;
         oErr <= state == sIdle && iStart && !legal;
      end
endmodule

// File: doc/coeff_bus_initiator.md
Name: coeff_bus_initiator

Overview:
Host-side initiator for the FIR coefficient-update bus. It drives the update flag, chip-select, write-enable, address and data lines that the FIR controller decodes. It accepts a stream of N signed 16-bit coefficients over a valid/ready handshake and runs the full bus sequence: arm, setup, N write beats, an N-beat readback sweep, then close. The sequence leaves the FIR controller in its filtering (Output) state.

Parameters:
P_TAP_MAX, 64, maximum number of coefficients per update; fixes the address width at 6 bits.
P_DW, 16, coefficient data width, signed.

Ports:
iClk_12M  in  1  system clock, 12 MHz.
iRsn  in  1  reset, asynchronous, active-low.
iStart  in  1  single-cycle request to begin an update.
iNumTap  in  7  coefficient count N, sampled when iStart is accepted; legal range 1..64.
iCoeffValid  in  1  coefficient stream valid.
iCoeff  in  16  signed coefficient; the k-th accepted value goes to address k.
oCoeffReady  out  1  coefficient stream ready.
oCoeffiUpdateFlag  out  1  update flag to the FIR controller.
oCsnRam  out  1  chip select, active-low.
oWrnRam  out  1  write enable, active-low.
oAddrRam  out  6  coefficient address.
oWrDtRam  out  16  coefficient write data.
oBusy  out  1  high from the first cycle after an accepted start through the CLOSE cycle, inclusive.
oDone  out  1  one-cycle pulse in the CLOSE cycle.
oErr  out  1  one-cycle pulse, the cycle after a rejected start.

Behaviour:
- All bus outputs, oBusy, oDone and oErr are registered. oCoeffReady is combinational from state and count only; it never depends on iCoeffValid.
- Reset (asynchronous, any time, including mid-sequence) forces state IDLE and these values: flag=0, csn=1, wrn=1, addr=0, data=0, busy=0, done=0, err=0, ready=0. Counters clear.
- States and bus values (flag/csn/wrn):
  - IDLE: 0/1/1, addr=0, data=0.
    - iStart with 1<=iNumTap<=64: latch N, go to ARM.
    - iStart with iNumTap=0 or >64: stay in IDLE, pulse oErr the next cycle.
  - ARM (1 cycle): 1/1/0. Returns the controller from Output to Idle; has no effect if the controller is already Idle.
  - SETUP (1 cycle): 1/0/0, addr=0, data=0. This is the controller's Idle->Write trigger; the cycle itself is a sacrificial write that beat 0 overwrites.
  - WRITE: flag=1, wrn=0.
    - A beat accepted at cycle t (iCoeffValid & oCoeffReady) drives csn=0, addr=k, data=iCoeff at t+1, and increments the accept count k.
    - A cycle with no accepted beat drives csn=1 on the next cycle; addr and data hold their previous values.
    - When the N-th beat is on the bus, the next state is READ.
  - READ (N cycles): 0/0/1, addr sweeps 0,1,..,N-1, data=0.
  - CLOSE (1 cycle): 0/1/1, addr=0, oDone=1. Next state is IDLE.
- oCoeffReady = (state==SETUP or WRITE) and k<N. Acceptance can therefore start in SETUP, and at most N beats are accepted; extra valid beats are held off.
- iStart is ignored outside IDLE; no error is reported for it.
- Latency with all beats offered immediately (start sampled at cycle 0): ARM at 1, SETUP at 2, writes at 3..N+2, READ at N+3..2N+2, CLOSE/oDone at 2N+3. Total 2N+4 cycles.
- Address wrap: N=64 uses address 63 as the last address, and the count register does not overflow (k is 7 bits).
- Simultaneous start and reset: reset wins.

Test Plan:
1. Reset, then start with N=4 and coefficients 0x0001, 0xFFFF, 0x7FFF, 0x8000 always valid -> ARM@1, SETUP@2, write addresses 0..3 carrying those values @3..6, read addresses 0..3 @7..10, oDone@11, oBusy high 1..11.
2. N=3 with iCoeffValid deasserted for 2 cycles after beat 0 -> csn=1 for 2 cycles with addr held at 0 and flag=1, wrn=0; beats 1 and 2 follow at addresses 1 and 2; oDone 2 cycles later than the no-stall case.
3. Start with iNumTap=0, and separately with 65 -> no bus activity, oErr pulses one cycle after each start, oBusy stays 0.
4. N=64 with streaming valid -> last write at addr 63 @66, read sweep 0..63, oDone@131; oCoeffReady low after 64 accepts even with valid held high.
5. Assert iRsn low during READ of an N=8 run -> outputs go to reset values immediately (asynchronously); a new start then runs a complete, correct sequence.
6. Pulse iStart again during WRITE -> ignored, no oErr, sequence completes unchanged.
